ddr4_traffic_checker: RTL and testbench
=======================================

Name: ddr4_traffic_checker

Overview:
- Parametrised DDR4 traffic generator and checker on the 512-bit DDR user interface.
- On a start pulse it writes NUM_BURSTS bursts of BURST_LEN beats of a deterministic pattern from BASE_ADDR, then reads them back and compares every beat.
- Reports done, pass, mismatch count, first failing address and timeout.
- Sits beside the DDR4 controller for board bring-up and memory self-test.

Parameters:
- ADDR_W, 26, DDR user address width (word-granular).
- DATA_W, 512, data width; multiple of 32, max 512.
- SIZE_W, 7, burst-size field width.
- BURST_LEN, 4, beats per burst, 1..2^SIZE_W-1.
- NUM_BURSTS, 8, bursts per test, >=1.
- BASE_ADDR, 0, first word address.
- SEED, 32'h1234_5678, pattern seed.
- TIMEOUT_CYC, 1024, idle cycles tolerated while waiting for read data.

Ports:
- sync_clk, in, 1, clock.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle start pulse; ignored unless the FSM is in IDLE or DONE.
- mode, in, 2, 0 = write+read-check, 1 = write only, 2 = read-check only, 3 = treated as 0.
- avl_ready, in, 1, controller accepts the current request/beat.
- avl_rdata_valid, in, 1, read beat valid.
- avl_rdata, in, DATA_W, read data.
- avl_addr, out, ADDR_W, burst start address.
- avl_wdata, out, DATA_W, write data.
- avl_be, out, DATA_W/8, byte enables.
- avl_read_req, out, 1, read request.
- avl_write_req, out, 1, write beat request.
- avl_size, out, SIZE_W, burst length.
- busy, out, 1, test in progress.
- done, out, 1, test finished; held until next accepted start.
- pass, out, 1, valid when done: no mismatches and no timeout.
- timeout, out, 1, read wait exceeded TIMEOUT_CYC.
- err_cnt, out, 16, mismatching beats; saturates at 16'hFFFF.
- first_err_addr, out, ADDR_W, word address of first mismatch.

Behaviour:
- Reset (async): all outputs 0, FSM to IDLE, all counters 0. Reset mid-test aborts immediately with no further requests. avl_rdata_valid arriving after reset is ignored.
- Pattern: word n at address A = BASE_ADDR + n. 32-bit lane k of that word = SEED + (n<<4) + k, 32-bit wraparound.
- Handshake: a request/beat is accepted on a rising edge where req && avl_ready. Outputs hold stable until accepted. avl_read_req and avl_write_req are never both 1. avl_be is all ones whenever either request is asserted.
- avl_addr and avl_size are the burst start and BURST_LEN for every beat of a burst. Burst b address = BASE_ADDR + b*BURST_LEN.
- FSM states: IDLE, WR, RD_REQ, RD_WAIT, DONE.
- IDLE/DONE + start:
  - clear err_cnt, first_err_addr, timeout, pass and done; busy=1.
  - mode 2 → RD_REQ; otherwise → WR.
  - Requests appear on the cycle after start is sampled.
- WR:
  - avl_write_req=1 with beat-0 data of burst 0.
  - Each accepted beat advances to the next word on the following cycle, with no bubble if avl_ready stays high.
  - After the last beat of the last burst is accepted, avl_write_req=0 next cycle. Mode 1 → DONE; otherwise → RD_REQ with burst counter reset.
- RD_REQ: avl_read_req=1 for the current burst, held until accepted; then 0 next cycle → RD_WAIT.
- RD_WAIT:
  - Each avl_rdata_valid beat is compared against the expected word (burst base + beat counter).
  - On mismatch: err_cnt increments (saturating). If it was the first mismatch, first_err_addr captures the word address.
  - After BURST_LEN beats: next burst → RD_REQ, or after the last burst → DONE.
  - Timeout counter reloads on entering RD_WAIT and on each valid beat. When it reaches TIMEOUT_CYC: timeout=1, → DONE.
- avl_rdata_valid outside RD_WAIT is ignored and not counted.
- DONE: busy=0, done=1, pass = (err_cnt==0) && !timeout. Start here restarts the test; start while busy is ignored.
- Throughput: full-rate writes at 1 beat/cycle. Reads are one burst outstanding at a time.

Test Plan:
- BURST_LEN=4, NUM_BURSTS=2, mode 0, avl_ready=1, ideal memory model → 8 write beats on 8 consecutive cycles with addr 0/4 and size 4; lane0 of word 5 = 32'h1234_56C8; 2 read requests; done=1, pass=1, err_cnt=0.
- Same config, avl_ready toggled randomly → identical write data sequence with no beat dropped or duplicated; pass=1.
- Memory model flips bit 0 of word 6 → err_cnt=1, first_err_addr=6, pass=0.
- Memory returns only 3 beats of burst 1, TIMEOUT_CYC=16 → timeout=1 sixteen cycles after the last beat, done=1, pass=0.
- Mode 1, then mode 2 on a memory model that retains data → first run issues no read requests and reaches done with pass=1; second run issues no write requests and passes. start pulsed while busy is ignored.
- reset_n asserted mid-WR, then start → all outputs 0 during reset; test restarts from address 0 and passes.

Source files
------------

// File: rtl/ddr4_traffic_checker.sv
// DDR4 user-interface traffic generator/checker: writes a seeded pattern in bursts,
// reads it back one burst at a time, and reports mismatches and read timeouts.
module ddr4_traffic_checker #(
  parameter int          ADDR_W      = 26,
  parameter int          DATA_W      = 512,
  parameter int          SIZE_W      = 7,
  parameter int          BURST_LEN   = 4,
  parameter int          NUM_BURSTS  = 8,
  parameter int          BASE_ADDR   = 0,
  parameter logic [31:0] SEED        = 32'h1234_5678,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                  sync_clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  avl_ready,
  input  logic                  avl_rdata_valid,
  input  logic [DATA_W-1:0]     avl_rdata,
  output logic [ADDR_W-1:0]     avl_addr,
  output logic [DATA_W-1:0]     avl_wdata,
  output logic [DATA_W/8-1:0]   avl_be,
  output logic                  avl_read_req,
  output logic                  avl_write_req,
  output logic [SIZE_W-1:0]     avl_size,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           err_cnt,
  output logic [ADDR_W-1:0]     first_err_addr
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int BW    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  localparam int LANES = DATA_W / 32;

  localparam logic [BW-1:0]     LAST_BURST = BW'(NUM_BURSTS - 1);
  localparam logic [SIZE_W-1:0] LAST_BEAT  = SIZE_W'(BURST_LEN - 1);

  // Word n of the test: lane k carries SEED + (n << 4) + k, modulo 2^32.
  function automatic logic [DATA_W-1:0] pattern_word(input logic [31:0] n);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int k = 0; k < LANES; k++) begin
      w[k*32 +: 32] = SEED + (n << 4) + 32'(k);
    end
    return w;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [SIZE_W-1:0] beat_q, beat_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
  logic              timeout_q, timeout_d;
  logic              pass_q, pass_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              wr_only_q, wr_only_d;

  logic [31:0]       word_idx;
  logic [31:0]       burst_off;
  logic [ADDR_W-1:0] burst_addr;
  logic [DATA_W-1:0] exp_word;
  logic              wr_req;
  logic              rd_req;

  assign burst_off  = 32'(burst_q) * 32'(BURST_LEN);
  assign word_idx   = burst_off + 32'(beat_q);
  assign burst_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(burst_off);
  assign exp_word   = pattern_word(word_idx);
  assign wr_req     = (state_q == S_WR);
  assign rd_req     = (state_q == S_RD_REQ);

  // Request-side fields are forced to zero when nothing is being requested.
  assign avl_write_req  = wr_req;
  assign avl_read_req   = rd_req;
  assign avl_addr       = (wr_req || rd_req) ? burst_addr : '0;
  assign avl_size       = (wr_req || rd_req) ? SIZE_W'(BURST_LEN) : '0;
  assign avl_be         = (wr_req || rd_req) ? '1 : '0;
  assign avl_wdata      = wr_req ? exp_word : '0;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_addr_q;

  always_comb begin
    state_d          = state_q;
    burst_d          = burst_q;
    beat_d           = beat_q;
    to_cnt_d         = to_cnt_q;
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;
    timeout_d        = timeout_q;
    pass_d           = pass_q;
    done_d           = done_q;
    busy_d           = busy_q;
    wr_only_d        = wr_only_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_cnt_d        = '0;
          first_err_addr_d = '0;
          timeout_d        = 1'b0;
          pass_d           = 1'b0;
          done_d           = 1'b0;
          busy_d           = 1'b1;
          burst_d          = '0;
          beat_d           = '0;
          to_cnt_d         = '0;
          wr_only_d        = (mode == 2'd1);
          state_d          = (mode == 2'd2) ? S_RD_REQ : S_WR;
        end
      end
      S_WR: begin
        if (avl_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (burst_q == LAST_BURST) begin
              burst_d = '0;
              state_d = wr_only_q ? S_DONE : S_RD_REQ;
            end else begin
              burst_d = burst_q + BW'(1);
            end
          end else begin
            beat_d = beat_q + SIZE_W'(1);
          end
        end
      end
      S_RD_REQ: begin
        if (avl_ready) begin
          state_d  = S_RD_WAIT;
          beat_d   = '0;
          to_cnt_d = '0;
        end
      end
      S_RD_WAIT: begin
        if (avl_rdata_valid) begin
          to_cnt_d = '0;
          if (avl_rdata != exp_word) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (err_cnt_q == 16'd0) first_err_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(word_idx);
          end
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (burst_q == LAST_BURST) begin
              state_d = S_DONE;
            end else begin
              burst_d = burst_q + BW'(1);
              state_d = S_RD_REQ;
            end
          end else begin
            beat_d = beat_q + SIZE_W'(1);
          end
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
          if (to_cnt_d == TW'(TIMEOUT_CYC)) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Verdict is latched on entry to DONE using the final error/timeout values.
    if (state_d == S_DONE && state_q != S_DONE) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      pass_d = (err_cnt_d == 16'd0) && !timeout_d;
    end
  end

  always_ff @(posedge sync_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      burst_q          <= '0;
      beat_q           <= '0;
      to_cnt_q         <= '0;
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
      timeout_q        <= 1'b0;
      pass_q           <= 1'b0;
      done_q           <= 1'b0;
      busy_q           <= 1'b0;
      wr_only_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      burst_q          <= burst_d;
      beat_q           <= beat_d;
      to_cnt_q         <= to_cnt_d;
      err_cnt_q        <= err_cnt_d;
      first_err_addr_q <= first_err_addr_d;
      timeout_q        <= timeout_d;
      pass_q           <= pass_d;
      done_q           <= done_d;
      busy_q           <= busy_d;
      wr_only_q        <= wr_only_d;
    end
  end

endmodule

// File: tb/tb_ddr4_traffic_checker.sv
// Directed bench for ddr4_traffic_checker with a small word-addressed memory model
// that can corrupt or drop read beats.
module tb_ddr4_traffic_checker;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 512;
  localparam int SIZE_W = 7;
  localparam int BL     = 4;
  localparam int NB     = 2;

  logic                sync_clk;
  logic                reset_n;
  logic                start;
  logic [1:0]          mode;
  logic                avl_ready;
  logic                avl_rdata_valid;
  logic [DATA_W-1:0]   avl_rdata;
  logic [ADDR_W-1:0]   avl_addr;
  logic [DATA_W-1:0]   avl_wdata;
  logic [DATA_W/8-1:0] avl_be;
  logic                avl_read_req;
  logic                avl_write_req;
  logic [SIZE_W-1:0]   avl_size;
  logic                busy;
  logic                done;
  logic                pass;
  logic                timeout;
  logic [15:0]         err_cnt;
  logic [ADDR_W-1:0]   first_err_addr;

  ddr4_traffic_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .BURST_LEN(BL),
    .NUM_BURSTS(NB), .BASE_ADDR(0), .SEED(32'h1234_5678), .TIMEOUT_CYC(16)
  ) dut (
    .sync_clk(sync_clk), .reset_n(reset_n), .start(start), .mode(mode),
    .avl_ready(avl_ready), .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata),
    .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_be(avl_be),
    .avl_read_req(avl_read_req), .avl_write_req(avl_write_req), .avl_size(avl_size),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_cnt(err_cnt), .first_err_addr(first_err_addr)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [DATA_W-1:0] mem [0:15];
  logic [DATA_W-1:0] rdq [$];
  logic [DATA_W-1:0] wlog_data [0:15];
  logic [ADDR_W-1:0] wlog_addr [0:15];
  logic [SIZE_W-1:0] wlog_size [0:15];
  logic [DATA_W/8-1:0] wlog_be [0:15];
  int wlog_cyc [0:15];
  int wcount, wr_beat, rd_req_cnt, last_beat_cyc, to_cyc;
  int flip_word = -1;
  int drop_word = -1;
  bit rand_ready = 0;

  task automatic chk_eq(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_word(input int n);
    logic [DATA_W-1:0] w;
    for (int k = 0; k < DATA_W/32; k++) w[k*32 +: 32] = 32'h1234_5678 + 32'(n) * 32'd16 + 32'(k);
    return w;
  endfunction

  initial begin
    sync_clk = 1'b0;
    forever #5 sync_clk = ~sync_clk;
  end

  initial forever begin
    @(posedge sync_clk);
    cyc++;
  end

  // Memory model: drives ready/read data at the falling edge, logs handshakes that will complete next edge.
  initial begin
    avl_ready = 1'b0;
    avl_rdata_valid = 1'b0;
    avl_rdata = '0;
    forever begin
      @(negedge sync_clk);
      if (rdq.size() > 0) begin
        avl_rdata_valid = 1'b1;
        avl_rdata = rdq.pop_front();
        last_beat_cyc = cyc + 1;
      end else begin
        avl_rdata_valid = 1'b0;
        avl_rdata = '0;
      end
      avl_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (avl_write_req && avl_ready && wcount < 16) begin
        wlog_data[wcount] = avl_wdata;
        wlog_addr[wcount] = avl_addr;
        wlog_size[wcount] = avl_size;
        wlog_be[wcount]   = avl_be;
        wlog_cyc[wcount]  = cyc + 1;
        mem[(int'(avl_addr[3:0]) + wr_beat) % 16] = avl_wdata;
        wr_beat = (wr_beat == BL - 1) ? 0 : wr_beat + 1;
        wcount++;
      end
      if (avl_read_req && avl_ready) begin
        rd_req_cnt++;
        for (int i = 0; i < BL; i++) begin
          int w;
          w = (int'(avl_addr[3:0]) + i) % 16;
          if (w != drop_word) rdq.push_back(mem[w] ^ ((w == flip_word) ? 512'd1 : 512'd0));
        end
      end
    end
  end

  task automatic tick();
    @(negedge sync_clk);
    #2;
  endtask

  task automatic clear_logs();
    wcount = 0;
    wr_beat = 0;
    rd_req_cnt = 0;
    last_beat_cyc = -1;
    to_cyc = -1;
    rdq.delete();
  endtask

  task automatic run_test(input logic [1:0] m, input bit poke);
    bit seen;
    clear_logs();
    mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (poke) begin
      repeat (2) tick();
      mode = 2'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      mode = m;
      chk_eq("busy_start_ignored", busy, 1);
    end
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (timeout && to_cyc < 0) to_cyc = cyc;
      if (done) begin
        seen = 1;
        break;
      end
    end
    chk_eq("done_reached", seen, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no summary expected summary within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int wc_at_rst;
    reset_n = 1'b0;
    start = 1'b0;
    mode = 2'd0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    clear_logs();
    repeat (3) tick();
    chk_eq("rst_ctrl", {busy, done, pass, timeout, avl_write_req, avl_read_req}, 0);
    chk_eq("rst_err_cnt", err_cnt, 0);
    chk_eq("rst_first_err", first_err_addr, 0);
    chk_eq("rst_addr_size_be", {avl_addr, avl_size, avl_be}, 0);
    chk_eq("rst_wdata", avl_wdata, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Basic write + read-check with an always-ready controller.
    run_test(2'd0, 0);
    chk_eq("t1_wcount", wcount, 8);
    chk_eq("t1_wr_span", wlog_cyc[7] - wlog_cyc[0], 7);
    chk_eq("t1_addr_b0", wlog_addr[0], 0);
    chk_eq("t1_addr_b0_last", wlog_addr[3], 0);
    chk_eq("t1_addr_b1", wlog_addr[4], 4);
    chk_eq("t1_addr_b1_last", wlog_addr[7], 4);
    chk_eq("t1_size", wlog_size[0], 4);
    chk_eq("t1_be", wlog_be[0], {64{1'b1}});
    chk_eq("t1_w5_lane0", wlog_data[5][31:0], 32'h1234_56C8);
    chk_eq("t1_w0_lane15", wlog_data[0][511:480], 32'h1234_5687);
    chk_eq("t1_rd_reqs", rd_req_cnt, 2);
    chk_eq("t1_status", {busy, done, pass, timeout}, 4'b0110);
    chk_eq("t1_err_cnt", err_cnt, 0);

    // Backpressured writes must keep the exact pattern order.
    rand_ready = 1;
    run_test(2'd0, 0);
    rand_ready = 0;
    chk_eq("t2_wcount", wcount, 8);
    for (int i = 0; i < 8; i++) begin
      chk_eq($sformatf("t2_wdata%0d", i), wlog_data[i], exp_word(i));
      chk_eq($sformatf("t2_waddr%0d", i), wlog_addr[i], (i / BL) * BL);
    end
    chk_eq("t2_pass", {done, pass}, 2'b11);

    // Single-bit corruption on word 6.
    flip_word = 6;
    run_test(2'd0, 0);
    flip_word = -1;
    chk_eq("t3_err_cnt", err_cnt, 1);
    chk_eq("t3_first_err", first_err_addr, 6);
    chk_eq("t3_status", {done, pass, timeout}, 3'b100);

    // Last beat of burst 1 never arrives.
    drop_word = 7;
    run_test(2'd0, 0);
    drop_word = -1;
    chk_eq("t4_status", {done, pass, timeout}, 3'b101);
    chk_eq("t4_to_delay", to_cyc - last_beat_cyc, 16);
    chk_eq("t4_err_cnt", err_cnt, 0);

    // Write-only into cleared memory, then read-only against what was written.
    for (int i = 0; i < 16; i++) mem[i] = '0;
    run_test(2'd1, 1);
    chk_eq("t5w_rd_reqs", rd_req_cnt, 0);
    chk_eq("t5w_wcount", wcount, 8);
    chk_eq("t5w_status", {busy, done, pass}, 3'b011);
    run_test(2'd2, 0);
    chk_eq("t5r_wcount", wcount, 0);
    chk_eq("t5r_rd_reqs", rd_req_cnt, 2);
    chk_eq("t5r_status", {done, pass, err_cnt}, {2'b11, 16'd0});

    // Reset in the middle of the write phase, then a clean rerun.
    clear_logs();
    mode = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (wcount >= 3) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk_eq("t6_reached_wr", ok, 1);
    reset_n = 1'b0;
    #1;
    chk_eq("t6_rst_ctrl", {busy, done, pass, timeout, avl_write_req, avl_read_req}, 0);
    chk_eq("t6_rst_bus", {avl_addr, avl_size, avl_be, err_cnt}, 0);
    chk_eq("t6_rst_wdata", avl_wdata, 0);
    wc_at_rst = wcount;
    repeat (3) tick();
    chk_eq("t6_no_wr_in_rst", wcount - wc_at_rst, 0);
    reset_n = 1'b1;
    tick();
    chk_eq("t6_idle_after", {busy, avl_write_req, avl_read_req}, 0);
    run_test(2'd0, 0);
    chk_eq("t6_addr0", wlog_addr[0], 0);
    chk_eq("t6_wdata0", wlog_data[0], exp_word(0));
    chk_eq("t6_wcount", wcount, 8);
    chk_eq("t6_status", {done, pass, err_cnt}, {2'b11, 16'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
